if_fetch_ctrl: RTL and testbench



---
 rtl/if_pkg.sv | 43 ++++
 rtl/if_fetch_fifo.sv | 86 ++++++++
 rtl/if_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// ============================================================================
// if_pkg
// Shared types and constants for the instruction-fetch controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_pkg;

   // Buffer depth between memory return and decode.
   localparam int IF_FIFO_DEPTH = 2;
   // Width of an occupancy count that can hold 0..IF_FIFO_DEPTH.
   localparam int IF_CNT_W      = $clog2(IF_FIFO_DEPTH + 1);

   // Default-configuration widths, used by the entry type below.
   localparam int IF_ADDR_W     = 32;
   localparam int IF_DATA_W     = 32;

   typedef enum logic [0:0] {
      FS_BOOT = 1'b0,
      FS_RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [IF_ADDR_W-1:0] pc;
      logic [IF_DATA_W-1:0] data;
   } fetch_entry_t;

   // A new read may start only if, after this cycle's pop, the buffered
   // words plus the word in flight leave room for the new one to land.
   function automatic logic can_issue(input logic [IF_CNT_W-1:0] count,
                                      input logic                inflight,
                                      input logic                pop);
      logic [IF_CNT_W:0] occ;
      logic [IF_CNT_W:0] limit;
      occ   = {1'b0, count} + {{IF_CNT_W{1'b0}}, inflight};
      limit = {{IF_CNT_W{1'b0}}, 1'b1} + {{IF_CNT_W{1'b0}}, pop};
      return (occ <= limit);
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// if_fetch_fifo
// Two-entry shift FIFO for fetched words. Entry 0 is always the head, so
// the head value simply holds when the FIFO drains or is flushed.
// Flush has priority over push.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic                flush_i,
   input  logic [W-1:0]        din_i,
   output logic [W-1:0]        head_o,
   output logic                valid_o,
   output logic [IF_CNT_W-1:0] count_o
);

   logic [W-1:0]        e0_q, e0_d;
   logic [W-1:0]        e1_q, e1_d;
   logic [IF_CNT_W-1:0] count_q, count_d;

   // Next-state for entries and count; entries are only overwritten when a
   // live value must move into them.
   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else begin
         case ({push_i, pop_i})
            2'b11: begin
               if (count_q == IF_CNT_W'(2)) begin
                  e0_d = e1_q;
                  e1_d = din_i;
               end else begin
                  e0_d = din_i;
               end
            end
            2'b01: begin
               if (count_q == IF_CNT_W'(2)) begin
                  e0_d = e1_q;
               end
               count_d = count_q - IF_CNT_W'(1);
            end
            2'b10: begin
               if (count_q == '0) begin
                  e0_d = din_i;
               end else begin
                  e1_d = din_i;
               end
               count_d = count_q + IF_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= '0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign head_o  = e0_q;
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// if_fetch_ctrl
// IF-stage fetch controller: owns the PC, issues word reads to a
// one-cycle-latency memory, buffers returns and hands them to decode.
// Redirects flush the buffer and drop the word in flight.
// Optional build macro: IF_FETCH_PERF_EN adds fetch/flush counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   // MEM_DEPTH is a power of two, so modulo reduces to a mask.
   localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);
   localparam int                ENT_W   = ADDR_W + DATA_W;

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

   logic                pop;
   logic                issue;
   logic                fifo_valid;
   logic [IF_CNT_W-1:0] fifo_count;
   logic [ENT_W-1:0]    fifo_head;

   assign pop = fifo_valid & inst_ready;

   // Next state, PC advance and in-flight tracking.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      issue         = 1'b0;

      case (state_q)
         FS_BOOT: state_d = FS_RUN;
         default: ;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_pc & PC_MASK;
      end else if ((state_q == FS_RUN) && can_issue(fifo_count, inflight_q, pop)) begin
         issue         = 1'b1;
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
         pc_d          = (pc_q + ADDR_W'(1)) & PC_MASK;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FS_BOOT;
         pc_q          <= RESET_PC & PC_MASK;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign mem_addr = pc_q;

   // The returning word lands whenever a read was issued last cycle; a
   // redirect this cycle flushes it away together with the buffer.
   if_fetch_fifo #(
      .W (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .din_i   ({inflight_pc_q, mem_rdata}),
      .head_o  (fifo_head),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign inst_valid = fifo_valid;
   assign inst_pc    = fifo_head[ENT_W-1 -: ADDR_W];
   assign inst_data  = fifo_head[DATA_W-1:0];

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Discarded words per redirect: buffered words not taken this cycle
   // plus whatever is returning from memory.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(pop);
      flush_cnt_d = flush_cnt_q;
      if (redirect_valid) begin
         flush_cnt_d = flush_cnt_q + 32'(fifo_count) - 32'(pop) + 32'(inflight_q);
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

   // Issue is internal only; kept as a named signal for waveform debug.
   logic unused_issue;
   assign unused_issue = issue;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// tb_if_fetch_ctrl
// Self-checking bench for if_fetch_ctrl with a synchronous memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;
   import if_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int exp_fetch = 0;
   int exp_flush = 0;

   logic [31:0]  mem [0:DEPTH-1];
   fetch_entry_t exp_q[$];

   if_fetch_ctrl #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_DEPTH (DEPTH),
      .RESET_PC  (32'd0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency memory.
   always @(posedge clk) mem_rdata <= mem[mem_addr[9:0]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int first, input int n);
      fetch_entry_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = 32'((first + i) % DEPTH);
         e.data = 32'hA000_0001 + e.pc;
         exp_q.push_back(e);
      end
   endtask

   // Drains the scoreboard with inst_ready high, comparing every handshake.
   task automatic run_stream(input int budget);
      fetch_entry_t e;
      bit seen = 1'b0;
      inst_ready = 1'b1;
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         if (inst_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (inst_pc !== e.pc || inst_data !== e.data) begin
               errors++;
               $display("FAIL stream_word: got pc=%0d data=%h, expected pc=%0d data=%h",
                        inst_pc, inst_data, e.pc, e.data);
            end
            exp_fetch++;
            seen = 1'b1;
         end else if (seen) begin
            checks++;
            errors++;
            $display("FAIL stream_bubble: inst_valid=0 mid-stream, expected 1");
         end
         step();
      end
      inst_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_timeout: %0d words still expected, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic settle();
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (inst_valid !== 1'b0 || mem_addr !== 32'd0 || inst_data !== 32'd0 || inst_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: valid=%b addr=%0d data=%h pc=%0d, expected 0 0 0 0",
                  inst_valid, mem_addr, inst_data, inst_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL boot_no_issue: mem_addr=%0d, expected 0", mem_addr);
      end
      step();
      checks++;
      if (inst_valid !== 1'b0 || mem_addr !== 32'd1) begin
         errors++;
         $display("FAIL first_issue: valid=%b addr=%0d, expected valid=0 addr=1", inst_valid, mem_addr);
      end
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_data !== 32'hA000_0001) begin
         errors++;
         $display("FAIL first_valid: valid=%b pc=%0d data=%h, expected 1 0 a0000001",
                  inst_valid, inst_pc, inst_data);
      end
   endtask

   task automatic test_stream();
      push_exp(0, 4);
      run_stream(20);
   endtask

   task automatic test_stall();
      inst_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (mem_addr !== 32'd6 || inst_valid !== 1'b1 || inst_pc !== 32'd4) begin
         errors++;
         $display("FAIL stall_freeze: addr=%0d valid=%b pc=%0d, expected addr=6 valid=1 pc=4",
                  mem_addr, inst_valid, inst_pc);
      end
      push_exp(4, 6);
      run_stream(30);
   endtask

   task automatic test_redirect_flush();
      settle();
      redirect(32'd0);
      exp_flush += 2;
      settle();
      redirect(32'd2);
      exp_flush += 2;
      checks++;
      if (mem_addr !== 32'd2 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_t1: addr=%0d valid=%b, expected addr=2 valid=0", mem_addr, inst_valid);
      end
      step();
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_t2: valid=%b, expected 0", inst_valid);
      end
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd2 || inst_data !== 32'hA000_0003) begin
         errors++;
         $display("FAIL redirect_t3: valid=%b pc=%0d data=%h, expected 1 2 a0000003",
                  inst_valid, inst_pc, inst_data);
      end
      push_exp(2, 3);
      run_stream(20);
   endtask

   task automatic test_redirect_pop();
      settle();
      redirect(32'd0);
      exp_flush += 2;
      settle();
      // Word 0 is taken in the same cycle as a redirect to 5.
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd5;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_data !== 32'hA000_0001) begin
         errors++;
         $display("FAIL pop_on_redirect: valid=%b pc=%0d data=%h, expected 1 0 a0000001",
                  inst_valid, inst_pc, inst_data);
      end
      exp_fetch++;
      exp_flush += 1;
      step();
      redirect_pc = 32'd0;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL second_redirect_empty: valid=%b, expected 0", inst_valid);
      end
      step();
      redirect_valid = 1'b0;
      push_exp(0, 3);
      run_stream(20);
   endtask

   task automatic test_wrap();
      settle();
      redirect(32'(DEPTH - 1));
      exp_flush += 2;
      checks++;
      if (mem_addr !== 32'(DEPTH - 1)) begin
         errors++;
         $display("FAIL wrap_target: addr=%0d, expected %0d", mem_addr, DEPTH - 1);
      end
      push_exp(DEPTH - 1, 3);
      run_stream(20);
   endtask

   task automatic test_async_reset();
      settle();
      checks++;
      if (inst_valid !== 1'b1 || mem_addr !== 32'd4) begin
         errors++;
         $display("FAIL full_before_reset: valid=%b addr=%0d, expected valid=1 addr=4", inst_valid, mem_addr);
      end
`ifdef IF_FETCH_PERF_EN
      checks++;
      if (perf_fetch_cnt !== 32'(exp_fetch) || perf_flush_cnt !== 32'(exp_flush)) begin
         errors++;
         $display("FAIL perf_counts: fetch=%0d flush=%0d, expected fetch=%0d flush=%0d",
                  perf_fetch_cnt, perf_flush_cnt, exp_fetch, exp_flush);
      end
`endif
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || mem_addr !== 32'd0 || inst_pc !== 32'd0 || inst_data !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: valid=%b addr=%0d pc=%0d data=%h, expected 0 0 0 0",
                  inst_valid, mem_addr, inst_pc, inst_data);
      end
`ifdef IF_FETCH_PERF_EN
      checks++;
      if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_reset: fetch=%0d flush=%0d, expected 0 0", perf_fetch_cnt, perf_flush_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(0, 2);
      run_stream(20);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0001 + 32'(i);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;

      test_reset();
      test_stream();
      test_stall();
      test_redirect_flush();
      test_redirect_pop();
      test_wrap();
      test_async_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
